// File: rtl/reg_mem_unit_if.sv
// Request/acknowledge bus of the register memory: one access per 4-phase handshake.
interface reg_mem_unit_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack;
  logic                  busy;

  modport master (
    output req, we, addr, data_in,
    input  data_out, ack, busy
  );

  modport slave (
    input  req, we, addr, data_in,
    output data_out, ack, busy
  );
endinterface

// File: rtl/reg_mem_unit.sv
// Flip-flop word memory behind a IDLE/ACCESS/DONE 4-phase request/acknowledge controller.
// Request fields are captured in IDLE, so the access uses only the captured copies.
module reg_mem_unit #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_mem_unit_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_reg, state_next;
  logic                  ack_reg, ack_next;
  logic                  we_l_reg;
  logic [ADDR_WIDTH-1:0] addr_l_reg;
  logic [DATA_WIDTH-1:0] data_l_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  latch_en;
  logic                  mem_we;
  logic                  rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    latch_en   = 1'b0;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        ack_next = 1'b0;
        if (bus.req) begin
          latch_en   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // Unconditional: a request dropped during ACCESS still completes.
        mem_we     = we_l_reg;
        rd_en      = !we_l_reg;
        ack_next   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (!bus.req) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_l_reg   <= 1'b0;
      addr_l_reg <= '0;
      data_l_reg <= '0;
    end else if (latch_en) begin
      we_l_reg   <= bus.we;
      addr_l_reg <= bus.addr;
      data_l_reg <= bus.data_in;
    end
  end

  // Each word is its own resettable register so reset clears the whole array at once.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem[gi] <= '0;
        else if (mem_we && (addr_l_reg == ADDR_WIDTH'(gi)))
          mem[gi] <= data_l_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data_out_reg <= '0;
    else if (rd_en)
      data_out_reg <= mem[addr_l_reg];
  end

  assign bus.data_out = data_out_reg;
  assign bus.ack      = ack_reg;
  assign bus.busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_reg_mem_unit.sv
// Randomised scoreboard bench for reg_mem_unit: a word-array model predicts DataOut at every Ack.
module tb_reg_mem_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  reg_mem_unit_if #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) bus ();

  reg_mem_unit #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] model_mem [8];
  logic [3:0] last_rd;
  logic [3:0] exp_q [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = 4'h0;
    last_rd = 4'h0;
    exp_q.delete();
  endtask

  // Asynchronous reset pulse asserted away from both clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ack", 8'(bus.ack), 8'h0);
    check("rst_async_busy", 8'(bus.busy), 8'h0);
    check("rst_async_dout", 8'(bus.data_out), 8'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset pulse");
  endtask

  task automatic access(input bit w, input logic [2:0] a, input logic [3:0] d,
                        input int hold, input bit abort);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.data_in = d;
    if (!abort) begin
      if (w) model_mem[a] = d;
      else   last_rd = model_mem[a];
      exp_q.push_back(last_rd);
    end
    @(negedge clk);
    check("ack_low_in_access", 8'(bus.ack), 8'h0);
    check("busy_in_access", 8'(bus.busy), 8'h1);
    // Request fields wander during ACCESS; the DUT must ignore them.
    bus.addr = 3'($urandom); bus.data_in = 4'($urandom); bus.we = 1'($urandom);
    if (abort) begin
      #2 rst_n = 1'b0;
      #1;
      check("abort_ack", 8'(bus.ack), 8'h0);
      check("abort_busy", 8'(bus.busy), 8'h0);
      check("abort_dout", 8'(bus.data_out), 8'h0);
      model_reset();
      @(negedge clk);
      bus.req = 1'b0;
      rst_n = 1'b1;
      $display("[TB] %s addr=%0d data=0x%0h aborted by reset", w ? "WR" : "RD", a, d);
      return;
    end
    @(negedge clk);
    check("ack_after_k1", 8'(bus.ack), 8'h1);
    check("busy_in_done", 8'(bus.busy), 8'h1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ack", 8'(bus.ack), 8'h1);
      check("hold_busy", 8'(bus.busy), 8'h1);
      check("hold_dout", 8'(bus.data_out), 8'(last_rd));
    end
    bus.req = 1'b0;
    @(negedge clk);
    check("ack_dropped", 8'(bus.ack), 8'h0);
    check("busy_dropped", 8'(bus.busy), 8'h0);
    $display("[TB] %s addr=%0d data=0x%0h hold=%0d dout=0x%0h", w ? "WR" : "RD", a,
             w ? d : last_rd, hold, bus.data_out);
  endtask

  // Monitor: every rising Ack must present the predicted DataOut.
  initial begin
    logic       prev_ack;
    logic [3:0] e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ack === 1'b1 && prev_ack !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=1 expected no access at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("dout_on_ack", 8'(bus.data_out), 8'(e));
        end
      end
      prev_ack = bus.ack;
    end
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_ack", 8'(bus.ack), 8'h0);
    check("reset_busy", 8'(bus.busy), 8'h0);
    check("reset_dout", 8'(bus.data_out), 8'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) access(1'b0, 3'(i), 4'h0, 0, 1'b0);

    access(1'b1, 3'd5, 4'hA, 0, 1'b0);
    access(1'b0, 3'd5, 4'h0, 0, 1'b0);

    // Input capture: junk on Addr/DataIn after the request edge must not leak to address 6.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 3'd2; bus.data_in = 4'h3;
    model_mem[2] = 4'h3;
    exp_q.push_back(last_rd);
    @(negedge clk);
    bus.addr = 3'd6; bus.data_in = 4'hF;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    $display("[TB] WR addr=2 data=0x3 with addr=6/data=0xF during ACCESS");
    access(1'b0, 3'd2, 4'h0, 0, 1'b0);
    access(1'b0, 3'd6, 4'h0, 0, 1'b0);

    access(1'b0, 3'd5, 4'h0, 5, 1'b0);
    access(1'b1, 3'd4, 4'hC, 5, 1'b0);

    pulse_reset();
    access(1'b0, 3'd5, 4'h0, 0, 1'b0);

    access(1'b1, 3'd1, 4'h7, 0, 1'b0);
    access(1'b0, 3'd1, 4'h0, 0, 1'b0);
    access(1'b1, 3'd1, 4'h9, 0, 1'b1);
    access(1'b0, 3'd1, 4'h0, 0, 1'b0);

    access(1'b0, 3'd3, 4'h0, 0, 1'b0);
    for (int i = 0; i < 8; i++) access(1'b1, 3'(i), 4'(i + 1), 0, 1'b0);
    for (int i = 0; i < 8; i++) access(1'b0, 3'(i), 4'h0, 0, 1'b0);

    for (int n = 0; n < 40; n++)
      access(1'($urandom), 3'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0);

    @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
